// File: rtl/fx3_slave_fifo_model.sv
// Behavioural-but-synthesizable model of an FX3 slave-FIFO interface: one egress
// socket (host -> bus master) and one ingress socket (bus master -> host).
module fx3_slave_fifo_model #(
   parameter int DEPTH      = 16,
   parameter int WATERMARK  = 4,
   parameter int RD_LATENCY = 2
) (
   input  logic        clk_pll,
   input  logic        reset_,
   input  logic        slcs_n,
   input  logic        slrd_n,
   input  logic        slwr_n,
   input  logic        sloe_n,
   input  logic        pktend_n,
   input  logic [1:0]  addr,
   input  logic [31:0] dq_in,
   output logic [31:0] dq_out,
   output logic        dq_oe,
   output logic        flaga,
   output logic        flagb,
   output logic        flagc,
   output logic        flagd,
   input  logic        h_wr_valid,
   input  logic [31:0] h_wr_data,
   output logic        h_wr_ready,
   output logic        h_rd_valid,
   output logic [31:0] h_rd_data,
   input  logic        h_rd_ready,
   output logic [15:0] pkt_cnt,
   output logic [2:0]  err_flags
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] WM_C    = CW'(WATERMARK);
   localparam logic [1:0]    ADDR_EG = 2'b11;
   localparam logic [1:0]    ADDR_IN = 2'b00;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DRAIN} state_t;

   typedef struct packed {
      logic        vld;
      logic [31:0] data;
   } stage_t;

   state_t         state_q, state_d;
   logic [31:0]    eg_mem [DEPTH];
   logic [31:0]    in_mem [DEPTH];
   logic [AW-1:0]  eg_wp_q, eg_wp_d, eg_rp_q, eg_rp_d;
   logic [AW-1:0]  in_wp_q, in_wp_d, in_rp_q, in_rp_d;
   logic [CW-1:0]  eg_cnt_q, eg_cnt_d, in_cnt_q, in_cnt_d;
   stage_t         pipe_q [RD_LATENCY];
   stage_t         pipe_d [RD_LATENCY];
   logic [31:0]    dq_out_q, dq_out_d;
   logic           dq_oe_q, dq_oe_d;
   logic           flaga_q, flaga_d, flagb_q, flagb_d;
   logic           flagc_q, flagc_d, flagd_q, flagd_d;
   logic           h_wr_ready_q, h_wr_ready_d;
   logic [15:0]    pkt_cnt_q, pkt_cnt_d;
   logic [2:0]     err_q, err_d;

   logic rd_strobe, wr_strobe, both_low, rd_act, wr_act, pkt_commit;
   logic eg_push, eg_pop, rd_under, in_push, in_pop, wr_over, wr_cont;
   logic pipe_busy, rd_wr_turn;

   // Bus decode: every action needs chip select in the same sampled cycle.
   assign rd_strobe  = ~slcs_n & ~slrd_n & (addr == ADDR_EG);
   assign wr_strobe  = ~slcs_n & ~slwr_n & (addr == ADDR_IN);
   assign both_low   = ~slcs_n & ~slrd_n & ~slwr_n;
   assign rd_act     = rd_strobe & slwr_n;
   assign wr_act     = wr_strobe & slrd_n;
   assign pkt_commit = ~slcs_n & ~pktend_n & (addr == ADDR_IN);

   assign h_rd_valid = (in_cnt_q != '0);
   assign h_rd_data  = in_mem[in_rp_q];

   assign eg_push  = h_wr_valid & h_wr_ready_q;
   assign eg_pop   = rd_act & (eg_cnt_q != '0);
   assign rd_under = rd_act & (eg_cnt_q == '0);
   assign wr_cont  = wr_act & dq_oe_q;
   assign in_push  = wr_act & ~dq_oe_q & (in_cnt_q != DEPTH_C);
   assign wr_over  = wr_act & ~dq_oe_q & (in_cnt_q == DEPTH_C);
   assign in_pop   = h_rd_valid & h_rd_ready;

   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_busy = pipe_busy | pipe_q[i].vld;
   end

   // FSM: state register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
   always_ff @(posedge clk_pll or negedge reset_) begin
      if (!reset_) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // FSM: next state
   // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rd_strobe)      state_d = ST_READ;
            else if (wr_strobe) state_d = ST_WRITE;
         end
         ST_READ: begin
            if (wr_strobe && !rd_strobe) state_d = ST_WRITE;
            else if (!rd_strobe)         state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (rd_strobe)       state_d = ST_READ;
            else if (!pipe_busy) state_d = ST_IDLE;
         end
         ST_WRITE: begin
            if (!wr_strobe) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs (turning the bus from read straight to write skips the drain)
   always_comb begin
      rd_wr_turn = 1'b0;
      if (state_q == ST_READ && state_d == ST_WRITE) rd_wr_turn = 1'b1;
   end

   // Datapath next-state
   always_comb begin
      eg_wp_d  = eg_push ? eg_wp_q + AW'(1) : eg_wp_q;
      eg_rp_d  = eg_pop  ? eg_rp_q + AW'(1) : eg_rp_q;
      in_wp_d  = in_push ? in_wp_q + AW'(1) : in_wp_q;
      in_rp_d  = in_pop  ? in_rp_q + AW'(1) : in_rp_q;
      eg_cnt_d = eg_cnt_q + CW'(eg_push) - CW'(eg_pop);
      in_cnt_d = in_cnt_q + CW'(in_push) - CW'(in_pop);

      pipe_d[0].vld  = eg_pop;
      pipe_d[0].data = eg_pop ? eg_mem[eg_rp_q] : '0;
      for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
      dq_out_d = pipe_q[RD_LATENCY-1].vld ? pipe_q[RD_LATENCY-1].data : '0;
      dq_oe_d  = ~sloe_n & ~slcs_n & (addr == ADDR_EG);

      flaga_d      = (DEPTH_C - in_cnt_d) != '0;
      flagb_d      = (DEPTH_C - in_cnt_d) > WM_C;
      flagc_d      = (eg_cnt_d != '0);
      flagd_d      = (eg_cnt_d > WM_C);
      h_wr_ready_d = (eg_cnt_d != DEPTH_C);

      pkt_cnt_d = pkt_commit ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
      err_d     = err_q | {both_low | wr_cont | rd_wr_turn, wr_over, rd_under};
   end

   always_ff @(posedge clk_pll or negedge reset_) begin
      if (!reset_) begin
         eg_wp_q      <= '0;
         eg_rp_q      <= '0;
         in_wp_q      <= '0;
         in_rp_q      <= '0;
         eg_cnt_q     <= '0;
         in_cnt_q     <= '0;
         for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
         dq_out_q     <= '0;
         dq_oe_q      <= 1'b0;
         flaga_q      <= 1'b1;
         flagb_q      <= 1'b1;
         flagc_q      <= 1'b0;
         flagd_q      <= 1'b0;
         h_wr_ready_q <= 1'b0;
         pkt_cnt_q    <= '0;
         err_q        <= '0;
      end else begin
         eg_wp_q      <= eg_wp_d;
         eg_rp_q      <= eg_rp_d;
         in_wp_q      <= in_wp_d;
         in_rp_q      <= in_rp_d;
         eg_cnt_q     <= eg_cnt_d;
         in_cnt_q     <= in_cnt_d;
         for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= pipe_d[i];
         dq_out_q     <= dq_out_d;
         dq_oe_q      <= dq_oe_d;
         flaga_q      <= flaga_d;
         flagb_q      <= flagb_d;
         flagc_q      <= flagc_d;
         flagd_q      <= flagd_d;
         h_wr_ready_q <= h_wr_ready_d;
         pkt_cnt_q    <= pkt_cnt_d;
         err_q        <= err_d;
      end
   end

   // NOTE: storage arrays carry no reset; zeroed pointers and counts already make them empty.
   always_ff @(posedge clk_pll) begin
      if (eg_push) eg_mem[eg_wp_q] <= h_wr_data;
      if (in_push) in_mem[in_wp_q] <= dq_in;
   end

   assign dq_out     = dq_out_q;
   assign dq_oe      = dq_oe_q;
   assign flaga      = flaga_q;
   assign flagb      = flagb_q;
   assign flagc      = flagc_q;
   assign flagd      = flagd_q;
   assign h_wr_ready = h_wr_ready_q;
   assign pkt_cnt    = pkt_cnt_q;
   assign err_flags  = err_q;

endmodule

// File: tb/tb_fx3_slave_fifo_model.sv
// Directed bench for fx3_slave_fifo_model: inputs change on the falling edge,
// outputs are compared on the falling edge against hand-computed values.
module tb_fx3_slave_fifo_model;

   logic        clk_pll = 1'b0;
   logic        reset_  = 1'b0;
   logic        slcs_n = 1'b1, slrd_n = 1'b1, slwr_n = 1'b1, sloe_n = 1'b1, pktend_n = 1'b1;
   logic [1:0]  addr = 2'b00;
   logic [31:0] dq_in = '0;
   logic [31:0] dq_out;
   logic        dq_oe, flaga, flagb, flagc, flagd;
   logic        h_wr_valid = 1'b0;
   logic [31:0] h_wr_data = '0;
   logic        h_wr_ready;
   logic        h_rd_valid;
   logic [31:0] h_rd_data;
   logic        h_rd_ready = 1'b0;
   logic [15:0] pkt_cnt;
   logic [2:0]  err_flags;

   int n_cmp = 0;
   int n_mis = 0;

   fx3_slave_fifo_model dut (
      .clk_pll(clk_pll), .reset_(reset_),
      .slcs_n(slcs_n), .slrd_n(slrd_n), .slwr_n(slwr_n), .sloe_n(sloe_n), .pktend_n(pktend_n),
      .addr(addr), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
      .flaga(flaga), .flagb(flagb), .flagc(flagc), .flagd(flagd),
      .h_wr_valid(h_wr_valid), .h_wr_data(h_wr_data), .h_wr_ready(h_wr_ready),
      .h_rd_valid(h_rd_valid), .h_rd_data(h_rd_data), .h_rd_ready(h_rd_ready),
      .pkt_cnt(pkt_cnt), .err_flags(err_flags)
   );

   always #5 clk_pll = ~clk_pll;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      slcs_n = 1'b1; slrd_n = 1'b1; slwr_n = 1'b1; sloe_n = 1'b1; pktend_n = 1'b1; addr = 2'b00;
   endtask

   task automatic do_reset();
      bus_idle();
      reset_ = 1'b0;
      @(negedge clk_pll);
      reset_ = 1'b1;
      @(negedge clk_pll);
   endtask

   // Word 0 is 'first', words 1..n-1 are their own index.
   task automatic host_load(input logic [31:0] first, input int n);
      h_wr_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         h_wr_data = (i == 0) ? first : 32'(i);
         @(negedge clk_pll);
      end
      h_wr_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      @(negedge clk_pll);
      check("rst_dq_out", dq_out, 32'h0);
      check("rst_dq_oe", 32'(dq_oe), 32'd0);
      check("rst_flaga", 32'(flaga), 32'd1);
      check("rst_flagb", 32'(flagb), 32'd1);
      check("rst_flagc", 32'(flagc), 32'd0);
      check("rst_flagd", 32'(flagd), 32'd0);
      check("rst_h_wr_ready", 32'(h_wr_ready), 32'd0);
      check("rst_h_rd_valid", 32'(h_rd_valid), 32'd0);
      reset_ = 1'b1;
      @(negedge clk_pll);
      check("post_rst_h_wr_ready", 32'(h_wr_ready), 32'd1);
      check("post_rst_err", 32'(err_flags), 32'd0);
      check("post_rst_pkt_cnt", 32'(pkt_cnt), 32'd0);

      // Five egress words: above watermark, then one pop drops flagd only
      host_load(32'h0000_0050, 5);
      check("wm_flagc_5", 32'(flagc), 32'd1);
      check("wm_flagd_5", 32'(flagd), 32'd1);
      slcs_n = 1'b0; slrd_n = 1'b0; addr = 2'b11;
      @(negedge clk_pll);
      bus_idle();
      check("wm_flagd_4", 32'(flagd), 32'd0);
      check("wm_flagc_4", 32'(flagc), 32'd1);
      @(negedge clk_pll);
      check("wm_dq_lat1", dq_out, 32'h0);
      @(negedge clk_pll);
      check("wm_dq_lat2", dq_out, 32'h0000_0050);

      // Eight-word streaming read
      do_reset();
      host_load(32'hCAFE_B0BA, 8);
      check("rd8_flagc_pre", 32'(flagc), 32'd1);
      check("rd8_flagd_pre", 32'(flagd), 32'd1);
      check("rd8_dq_oe_pre", 32'(dq_oe), 32'd0);
      slcs_n = 1'b0; sloe_n = 1'b0; slrd_n = 1'b0; addr = 2'b11;
      @(negedge clk_pll);
      check("rd8_dq_oe_on", 32'(dq_oe), 32'd1);
      check("rd8_dq_c1", dq_out, 32'h0);
      @(negedge clk_pll);
      check("rd8_dq_c2", dq_out, 32'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_pll);
         check($sformatf("rd8_word%0d", i), dq_out, (i == 0) ? 32'hCAFE_B0BA : 32'(i));
         if (i == 5) slrd_n = 1'b1;
      end
      @(negedge clk_pll);
      check("rd8_dq_tail", dq_out, 32'h0);
      check("rd8_flagc_post", 32'(flagc), 32'd0);
      check("rd8_err", 32'(err_flags), 32'd0);
      bus_idle();
      @(negedge clk_pll);
      check("rd8_dq_oe_off", 32'(dq_oe), 32'd0);

      // Reset in the middle of a read
      do_reset();
      host_load(32'hCAFE_B0BA, 8);
      slcs_n = 1'b0; sloe_n = 1'b0; slrd_n = 1'b0; addr = 2'b11;
      repeat (3) @(negedge clk_pll);
      check("mid_rst_word0", dq_out, 32'hCAFE_B0BA);
      reset_ = 1'b0;
      #1;
      check("mid_rst_dq_oe", 32'(dq_oe), 32'd0);
      check("mid_rst_flagc", 32'(flagc), 32'd0);
      check("mid_rst_dq_out", dq_out, 32'h0);
      @(negedge clk_pll);
      reset_ = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_pll);
         check($sformatf("mid_rst_nodata%0d", i), dq_out, 32'h0);
      end
      check("mid_rst_underflow", 32'(err_flags), 32'b001);
      check("mid_rst_h_wr_ready", 32'(h_wr_ready), 32'd1);
      bus_idle();

      // Fill ingress past full
      do_reset();
      slcs_n = 1'b0; slwr_n = 1'b0; addr = 2'b00;
      for (int i = 1; i <= 17; i++) begin
         dq_in = 32'h1000 + 32'(i);
         @(negedge clk_pll);
         if (i == 11) check("fill_flagb_11", 32'(flagb), 32'd1);
         if (i == 12) check("fill_flagb_12", 32'(flagb), 32'd0);
         if (i == 15) check("fill_flaga_15", 32'(flaga), 32'd1);
         if (i == 16) check("fill_flaga_16", 32'(flaga), 32'd0);
         if (i == 16) check("fill_err_16", 32'(err_flags), 32'b000);
         if (i == 17) check("fill_err_17", 32'(err_flags), 32'b010);
      end
      bus_idle();
      h_rd_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         check($sformatf("fill_drain%0d", i), h_rd_data, 32'h1000 + 32'(i));
         @(negedge clk_pll);
      end
      h_rd_ready = 1'b0;
      check("fill_drained", 32'(h_rd_valid), 32'd0);

      // Packet end on the third write
      do_reset();
      slcs_n = 1'b0; slwr_n = 1'b0; addr = 2'b00;
      dq_in = 32'hA000_0001;
      @(negedge clk_pll);
      dq_in = 32'hA000_0002;
      @(negedge clk_pll);
      dq_in = 32'hA000_0003; pktend_n = 1'b0;
      @(negedge clk_pll);
      bus_idle();
      check("pkt_cnt", 32'(pkt_cnt), 32'd1);
      h_rd_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         check($sformatf("pkt_drain%0d", i), h_rd_data, 32'hA000_0000 + 32'(i));
         @(negedge clk_pll);
      end
      h_rd_ready = 1'b0;
      check("pkt_drained", 32'(h_rd_valid), 32'd0);
      check("pkt_err", 32'(err_flags), 32'd0);

      // Read and write strobes together
      host_load(32'h0000_0070, 5);
      slcs_n = 1'b0; slwr_n = 1'b0; addr = 2'b00; dq_in = 32'hB000_0001;
      @(negedge clk_pll);
      bus_idle();
      check("both_one_word_ingress", 32'(h_rd_valid), 32'd1);
      slcs_n = 1'b0; slrd_n = 1'b0; slwr_n = 1'b0; addr = 2'b00; dq_in = 32'hB000_0002;
      @(negedge clk_pll);
      bus_idle();
      check("both_err", 32'(err_flags), 32'b100);
      check("both_flagd", 32'(flagd), 32'd1);
      check("both_head", h_rd_data, 32'hB000_0001);
      h_rd_ready = 1'b1;
      @(negedge clk_pll);
      h_rd_ready = 1'b0;
      check("both_ingress_one", 32'(h_rd_valid), 32'd0);

      // Write while the model drives the bus
      do_reset();
      slcs_n = 1'b0; sloe_n = 1'b0; addr = 2'b11;
      @(negedge clk_pll);
      check("cont_dq_oe", 32'(dq_oe), 32'd1);
      addr = 2'b00; slwr_n = 1'b0; dq_in = 32'hDEAD_BEEF;
      @(negedge clk_pll);
      bus_idle();
      check("cont_err", 32'(err_flags), 32'b100);
      check("cont_dropped", 32'(h_rd_valid), 32'd0);
      check("cont_dq_oe_off", 32'(dq_oe), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/fx3_slave_fifo_model.md
FX3_SLAVE_FIFO_MODEL -- requirements
Module: fx3_slave_fifo_model

Interface
REQ-001 Parameter DEPTH, default 16, words per socket buffer (power of two, 4..256).
REQ-002 Parameter WATERMARK, default 4, partial-flag threshold in words (1..DEPTH-2).
REQ-003 Parameter RD_LATENCY, default 2, cycles from SLRD sample to DQ valid (2..4).
REQ-004 clk_pll  in  1  clock, all logic rising-edge.
REQ-005 reset_  in  1  reset, asynchronous, active-low.
REQ-006 slcs_n, slrd_n, slwr_n, sloe_n, pktend_n  in  1 each  slave-FIFO strobes from FPGA master, active-low.
REQ-007 addr  in  2  socket select: 2'b11 egress (device->master), 2'b00 ingress (master->device); others select nothing.
REQ-008 dq_in  in  32  bus data from master; dq_out  out  32  bus data to master; dq_oe  out  1  model drives bus when 1.
REQ-009 flaga, flagb, flagc, flagd  out  1 each  socket status, registered.
REQ-010 h_wr_valid in 1, h_wr_data in 32, h_wr_ready out 1: host port loading egress buffer.
REQ-011 h_rd_valid out 1, h_rd_data out 32, h_rd_ready in 1: host port draining ingress buffer.
REQ-012 pkt_cnt  out  16  ingress packets committed; err_flags  out  3  sticky {protocol, overflow, underflow}.

Function
REQ-013 Strobes, addr, dq_in sampled on rising edge; action requires slcs_n=0 in the same cycle.
REQ-014 Egress read: slrd_n=0, addr=11, egress non-empty -> pop one word; word enters RD_LATENCY-stage pipeline.
REQ-015 dq_out = pipeline output when its valid bit set, else 32'h0; no combinational path from any input to dq_out.
REQ-016 dq_oe = registered (~sloe_n & ~slcs_n & addr==11); asserts 1 cycle after SLOE sampled low, deasserts 1 cycle after sampled high.
REQ-017 Read with egress empty -> no pop, underflow bit set, pipeline stage carries valid=0.
REQ-018 Ingress write: slwr_n=0, addr=00, dq_oe=0 -> push dq_in; when full -> word dropped, overflow bit set.
REQ-019 Write with dq_oe=1 (bus contention) -> word dropped, protocol bit set.
REQ-020 slrd_n=0 and slwr_n=0 in same cycle -> neither executes, protocol bit set.
REQ-021 pktend_n=0 with addr=00 -> pkt_cnt +1 (wraps 16'hFFFF->0); same-cycle write is pushed first, then committed.
REQ-022 flaga = 1 when ingress free >= 1; flagb = 1 when ingress free > WATERMARK; both from next-state counts, 1-cycle registered.
REQ-023 flagc = 1 when egress count >= 1; flagd = 1 when egress count > WATERMARK; same timing as REQ-022.
REQ-024 Counts width log2(DEPTH)+1; pointers log2(DEPTH), wrap DEPTH-1->0 without loss.
REQ-025 Same-cycle host push and bus pop on egress: both execute, count unchanged; same for bus push and host pop on ingress.
REQ-026 h_wr_ready = egress not full; h_rd_valid = ingress not empty; h_rd_data = ingress head word (first-word-fall-through).
REQ-027 Bus FSM states: IDLE, READ (slrd_n=0, addr=11), WRITE (slwr_n=0, addr=00), DRAIN (pipeline valid, no new read); IDLE->READ/WRITE on strobe, READ->DRAIN on slrd_n=1, DRAIN->IDLE when pipeline empty, WRITE->IDLE on slwr_n=1.
REQ-028 READ->WRITE direct transition (no DRAIN) sets protocol bit; write still follows REQ-019.
REQ-029 err_flags clear only by reset.

Reset
REQ-030 reset_ low: buffers empty, pointers/counts 0, pipeline invalid, FSM IDLE, pkt_cnt 0, err_flags 0.
REQ-031 During reset: dq_out 0, dq_oe 0, flaga 1, flagb 1, flagc 0, flagd 0, h_wr_ready 0, h_rd_valid 0.
REQ-032 Reset mid-transfer discards all buffered and in-flight words; h_wr_ready 1 on first cycle after release.

Verification
REQ-033 Host loads 8 words 0xCAFEB0BA,1..7; master holds slcs_n/sloe_n/slrd_n low, addr=11 -> flagc=1, flagd=1 before read; dq_out 0xCAFEB0BA exactly 2 cycles after first slrd sample, then 1..7 consecutive.
REQ-034 Egress loaded with 5 words, WATERMARK=4 -> flagd=1; one pop -> flagd=0 next cycle, flagc stays 1.
REQ-035 Master writes 16 words addr=00 -> flagb=0 after 12th, flaga=0 after 16th; 17th write -> dropped, err_flags=3'b010.
REQ-036 Write 3 words with pktend_n low on 3rd -> pkt_cnt=1; host drains 3 words in order.
REQ-037 slrd_n and slwr_n low same cycle -> err_flags=3'b100, egress/ingress counts unchanged.
REQ-038 reset_ pulsed during 8-word read -> dq_oe=0, flagc=0, dq_out=0 immediately; no further data returned.
